regfile_32x32: RTL and testbench
================================

REGFILE_32X32 -- requirements
Module: regfile_32x32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each register.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W = 32 registers.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port wvalid, input, 1, meaning a write request is presented.
REQ-006 SHALL have port wready_o, output, 1, meaning a write can be accepted this cycle.
REQ-007 SHALL have port waddr, input, ADDR_W, meaning the target register index.
REQ-008 SHALL have port wdata, input, WIDTH, meaning the write data.
REQ-009 SHALL have port clr_req, input, 1, meaning a request to start a sequential clear of all registers.
REQ-010 SHALL have port busy_o, output, 1, meaning a clear is in progress.
REQ-011 SHALL have port done_o, output, 1, meaning a one-cycle pulse that a clear has completed.
REQ-012 SHALL have port q_o, output, 32*WIDTH, meaning flat contents of all registers; register k occupies bits [k*WIDTH +: WIDTH], wired directly to d0..d31 of the downstream 32:1 mux.

Function
REQ-013 SHALL drive wready_o = !busy_o combinationally.
REQ-014 SHALL accept a write when wvalid && wready_o at a rising edge; reg[waddr] <= wdata.
REQ-015 SHALL show an accepted write on q_o on the cycle after the accepting edge (1-cycle latency); q_o SHALL be registered, with no combinational path from the write inputs.
REQ-016 SHALL ignore wvalid while busy_o = 1, with no register change.
REQ-017 SHALL implement the FSM IDLE -> CLEAR on clr_req in IDLE, and CLEAR -> IDLE after the last index is cleared.
REQ-018 SHALL load a 5-bit index counter with 0 on IDLE->CLEAR and assert busy_o from the next cycle.
REQ-019 SHALL, in CLEAR, zero reg[cnt] on each edge and increment cnt; at cnt = 31, reg[31] <= 0, state <= IDLE, and done_o is high for exactly the following cycle.
REQ-020 SHALL hold busy_o high for exactly 32 cycles per clear.
REQ-021 SHALL ignore clr_req while in CLEAR, with no restart and no extension.
REQ-022 SHALL, for simultaneous wvalid and clr_req in IDLE, perform the write on that edge and enter CLEAR; the written register is zeroed later by the clear.
REQ-023 SHALL leave registers with index >= cnt holding prior values during CLEAR; q_o reflects partial progress.
REQ-024 SHALL not wrap the index counter; the 31->0 transition only occurs via a new IDLE->CLEAR.

Reset
REQ-025 SHALL, on rst=1 at an edge, set all registers to 0 and state to IDLE, cnt = 0, busy_o = 0, and done_o = 0; wready_o is then 1.
REQ-026 SHALL give rst priority over writes and clear; rst during CLEAR aborts the clear with no done_o pulse.

Configuration
REQ-027 SHALL, with macro REGFILE_ZERO_REG_EN defined, hold register 0 at constant 0; writes to waddr=0 are accepted (wready_o honoured) but discarded.
REQ-028 SHALL, without REGFILE_ZERO_REG_EN, treat register 0 as writable like all others.

Verification
REQ-029 SHALL verify: after reset, write 32'hA0000000+i to reg i for i = 0..31 -> q_o slice i = A0000000+i one cycle after each write (reg 0 = 0 when REGFILE_ZERO_REG_EN is defined).
REQ-030 SHALL verify: pulse clr_req in IDLE -> busy_o high 32 cycles, reg k reads 0 from cycle k+1 after entry, done_o single-cycle pulse, then wready_o = 1.
REQ-031 SHALL verify: wvalid with waddr=5, wdata=32'hDEADBEEF during CLEAR -> wready_o = 0, reg 5 unchanged by the write.
REQ-032 SHALL verify: wvalid (waddr=31, wdata=32'h12345678) with clr_req on the same edge -> reg 31 = 12345678 until cleared at clear cycle 31, then 0.
REQ-033 SHALL verify: rst asserted at clear cycle 10 -> all registers 0, busy_o = 0, no done_o pulse.
REQ-034 SHALL verify: connect q_o to the 32:1 mux, sweep s = 0..31 after the fill -> y_o = A0000000+s.

Source files
------------

// File: rtl/regfile_32x32.sv
// 32-entry register file with a flat registered read bus and a sequential clear engine.
// Optional build macro REGFILE_ZERO_REG_EN makes register 0 read as constant zero.
module regfile_32x32 #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wvalid,
    output logic                            wready_o,
    input  logic [ADDR_W-1:0]               waddr,
    input  logic [WIDTH-1:0]                wdata,
    input  logic                            clr_req,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [(2**ADDR_W)*WIDTH-1:0]    q_o
);

    localparam int                 DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   regs_q [DEPTH];
    logic [WIDTH-1:0]   regs_d [DEPTH];
    logic               write_acc_s;

    // State, index counter, done pulse and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            done_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            regs_q  <= regs_d;
        end
    end

    // Next-state logic; the counter never wraps, it is only reloaded on entry to CLEAR
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy_o      = (state_q == CLEAR);
        wready_o    = !busy_o;
        done_o      = done_q;
        write_acc_s = wvalid && wready_o;
    end

    // Storage update: writes only land while idle, clear zeroes one entry per cycle
    always_comb begin
        regs_d = regs_q;
        if (state_q == CLEAR) begin
            regs_d[cnt_q] = {WIDTH{1'b0}};
        end else if (write_acc_s) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
`ifdef REGFILE_ZERO_REG_EN
        regs_d[0] = {WIDTH{1'b0}};
`endif
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign q_o[g*WIDTH +: WIDTH] = regs_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_32x32.sv
// Randomized self-checking bench for regfile_32x32 against a behavioural model.
module tb_regfile_32x32;

    localparam bit ZERO_REG =
`ifdef REGFILE_ZERO_REG_EN
        1'b1;
`else
        1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           wvalid;
    logic           wready_o;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic           clr_req;
    logic           busy_o;
    logic           done_o;
    logic [1023:0]  q_o;

    int n_checks;
    int n_fails;
    int busy_cnt;
    int done_cnt;

    // Reference model: register contents plus a clear-in-progress flag and position
    logic [31:0] m_reg [32];
    bit          m_clearing;
    int          m_idx;
    bit          m_done;

    regfile_32x32 #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wvalid   (wvalid),
        .wready_o (wready_o),
        .waddr    (waddr),
        .wdata    (wdata),
        .clr_req  (clr_req),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .q_o      (q_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int k);
        return q_o[k*32 +: 32];
    endfunction

    task automatic model_update(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                                input logic cr, input logic r);
        if (r) begin
            for (int k = 0; k < 32; k++) m_reg[k] = 32'h0;
            m_clearing = 1'b0;
            m_idx      = 0;
            m_done     = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_clearing) begin
                if (wv && !(ZERO_REG && wa == 5'd0)) m_reg[wa] = wd;
                if (cr) begin
                    m_clearing = 1'b1;
                    m_idx      = 0;
                end
            end else begin
                m_reg[m_idx] = 32'h0;
                if (m_idx == 31) begin
                    m_clearing = 1'b0;
                    m_done     = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    endtask

    task automatic cycle(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic cr, input logic r);
        wvalid  = wv;
        waddr   = wa;
        wdata   = wd;
        clr_req = cr;
        rst     = r;
        @(posedge clk);
        model_update(wv, wa, wd, cr, r);
        #1;
        if (busy_o === 1'b1) busy_cnt++;
        if (done_o === 1'b1) done_cnt++;
        check_eq("busy_o", {31'h0, busy_o}, {31'h0, m_clearing});
        check_eq("done_o", {31'h0, done_o}, {31'h0, m_done});
        check_eq("wready_o", {31'h0, wready_o}, {31'h0, !m_clearing});
        for (int k = 0; k < 32; k++) begin
            check_eq($sformatf("q[%0d]", k), slice(k), m_reg[k]);
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 32; k++) m_reg[k] = 32'h0;
        m_clearing = 1'b0;
        m_idx      = 0;
        m_done     = 1'b0;

        // Reset
        cycle(1'b1, 5'd3, 32'h5555_5555, 1'b1, 1'b1);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        check_eq("rst_wready", {31'h0, wready_o}, 32'h1);

        // Fill every register, each visible one cycle later
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 5'(i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            check_eq($sformatf("fill[%0d]", i), slice(i),
                     (ZERO_REG && i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i));
        end

        // Downstream 32:1 mux sweep
        for (int s = 0; s < 32; s++) begin
            logic [31:0] y;
            y = q_o[s*32 +: 32];
            check_eq($sformatf("mux[%0d]", s), y,
                     (ZERO_REG && s == 0) ? 32'h0 : 32'hA000_0000 + 32'(s));
        end

        // Sequential clear; write and re-request during clear are ignored
        busy_cnt = 0;
        done_cnt = 0;
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        for (int j = 1; j <= 34; j++) begin
            if (j == 3) begin
                cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
                check_eq("busy_wready", {31'h0, wready_o}, 32'h0);
                check_eq("reg5_kept", slice(5), 32'hA000_0005);
            end else begin
                cycle(1'b0, 5'd0, 32'h0, (j == 10 || j == 32) ? 1'b1 : 1'b0, 1'b0);
            end
            if (j <= 31) check_eq($sformatf("clr_prog[%0d]", j), slice(j - 1), 32'h0);
        end
        check_eq("busy_cycles", 32'(busy_cnt), 32'd32);
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        check_eq("post_wready", {31'h0, wready_o}, 32'h1);

        // Write and clear request on the same edge
        for (int i = 0; i < 32; i++) cycle(1'b1, 5'(i), $urandom, 1'b0, 1'b0);
        cycle(1'b1, 5'd31, 32'h1234_5678, 1'b1, 1'b0);
        for (int j = 1; j <= 33; j++) begin
            idle_cycle();
            if (j == 31) check_eq("r31_held", slice(31), 32'h1234_5678);
            if (j == 32) check_eq("r31_clr", slice(31), 32'h0);
        end

        // Reset in the middle of a clear aborts it without a done pulse
        for (int i = 0; i < 32; i++) cycle(1'b1, 5'(i), $urandom | 32'h1, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        for (int j = 1; j < 10; j++) idle_cycle();
        done_cnt = 0;
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) check_eq($sformatf("rst_abort[%0d]", k), slice(k), 32'h0);
        for (int j = 0; j < 35; j++) idle_cycle();
        check_eq("abort_done", 32'(done_cnt), 32'd0);
        check_eq("abort_busy", {31'h0, busy_o}, 32'h0);

        // Random traffic
        for (int j = 0; j < 600; j++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
